cpu_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding cpu_ctrl_unit. Owns fetch PC; fetches 16-bit instructions

---
 rtl/cpu_fetch_unit_if.sv | 25 ++
 rtl/cpu_fetch_unit.sv | 93 +++++++++
 tb/tb_cpu_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_unit_if.sv
// Instruction-memory fetch bus: the fetch unit (master) issues req/addr and
// instruction memory (slave) answers with ack/rdata.
interface cpu_fetch_unit_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, fetches one 16-bit instruction at a time
// over a req/ack bus, holds it for the control unit and follows execute-stage redirects.
module cpu_fetch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    cpu_fetch_unit_if.master   imem,
    input  logic               i_stall,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    output logic [3:0]         o_opcode,
    output logic [PC_W-1:0]    o_instr_pc,
    output logic [PC_W-1:0]    o_instr_pc_inc
);

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;

    localparam logic [PC_W-1:0] ALIGN_MASK = ~{{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] PC_STEP    = {{(PC_W-2){1'b0}}, 2'b10};

    logic [0:0]         r_state;
    logic [PC_W-1:0]    r_fetch_pc;
    logic               r_redir_pend;
    logic [PC_W-1:0]    r_redir_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;

    logic [PC_W-1:0]    w_redir_tgt;

    assign w_redir_tgt = i_redirect_pc & ALIGN_MASK;

    // A redirect seen while a request is outstanding cannot cancel it (the address must
    // stay stable until ack); it is parked in r_redir_pc and the returned data dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_fetch_pc   <= RESET_PC & ALIGN_MASK;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
            r_instr      <= '0;
            r_instr_pc   <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        if (i_redirect_valid) begin
                            r_fetch_pc   <= w_redir_tgt;
                            r_redir_pend <= 1'b0;
                        end else if (r_redir_pend) begin
                            r_fetch_pc   <= r_redir_pc;
                            r_redir_pend <= 1'b0;
                        end else begin
                            r_instr    <= imem.imem_rdata;
                            r_instr_pc <= r_fetch_pc;
                            r_fetch_pc <= r_fetch_pc + PC_STEP;
                            r_state    <= S_VALID;
                        end
                    end else if (i_redirect_valid) begin
                        r_redir_pend <= 1'b1;
                        r_redir_pc   <= w_redir_tgt;
                    end
                end
                S_VALID: begin
                    // Redirect beats stall; r_instr keeps its stale value behind instr_valid=0.
                    if (i_redirect_valid) begin
                        r_fetch_pc <= w_redir_tgt;
                        r_state    <= S_FETCH;
                    end else if (!i_stall) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Gated by rst_n so the request drops in the same cycle reset asserts.
    assign imem.imem_req  = rst_n & (r_state == S_FETCH);
    assign imem.imem_addr = r_fetch_pc;

    assign o_instr        = r_instr;
    assign o_instr_valid  = (r_state == S_VALID);
    assign o_opcode       = r_instr[INSTR_W-1 -: 4];
    assign o_instr_pc     = r_instr_pc;
    assign o_instr_pc_inc = r_instr_pc + PC_STEP;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed scenarios followed by randomized traffic checked
// against a transaction-level model of fetch/redirect behaviour.
module tb_cpu_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redir_v;
    logic [15:0] redir_pc;
    logic [15:0] instr, instr_pc, instr_pc_inc;
    logic        instr_valid;
    logic [3:0]  opcode;

    logic        stall2, redir_v2;
    logic [15:0] redir_pc2;
    logic [15:0] instr2, instr_pc2, instr_pc_inc2;
    logic        instr_valid2;
    logic [3:0]  opcode2;

    int checks = 0;
    int errors = 0;

    cpu_fetch_unit_if #(.PC_W(16), .INSTR_W(16)) bus ();
    cpu_fetch_unit_if #(.PC_W(16), .INSTR_W(16)) bus2 ();

    cpu_fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (bus),
        .i_stall          (stall),
        .i_redirect_valid (redir_v),
        .i_redirect_pc    (redir_pc),
        .o_instr          (instr),
        .o_instr_valid    (instr_valid),
        .o_opcode         (opcode),
        .o_instr_pc       (instr_pc),
        .o_instr_pc_inc   (instr_pc_inc)
    );

    cpu_fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (bus2),
        .i_stall          (stall2),
        .i_redirect_valid (redir_v2),
        .i_redirect_pc    (redir_pc2),
        .o_instr          (instr2),
        .o_instr_valid    (instr_valid2),
        .o_opcode         (opcode2),
        .o_instr_pc       (instr_pc2),
        .o_instr_pc_inc   (instr_pc_inc2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memv(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'hC3A5;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model state for the randomized phase
    logic        exp_valid, in_req, dirty;
    logic [15:0] req_addr, arch_next, m_ipc, tgt, exp_word;

    initial begin
        rst_n = 1'b0; stall = 1'b0; redir_v = 1'b0; redir_pc = 16'h0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0;
        stall2 = 1'b0; redir_v2 = 1'b0; redir_pc2 = 16'h0;
        bus2.imem_ack = 1'b1; bus2.imem_rdata = 16'h7E57;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req",    16'(bus.imem_req), 16'h0);
        chk("rst_valid",  16'(instr_valid), 16'h0);
        chk("rst_instr",  instr, 16'h0);
        chk("rst_ipc",    instr_pc, 16'h0);
        chk("rst_ipcinc", instr_pc_inc, 16'h2);
        chk("rst_req2",   16'(bus2.imem_req), 16'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_req",   16'(bus.imem_req), 16'h1);
        chk("rel_addr",  bus.imem_addr, 16'h0000);
        chk("rel_req2",  16'(bus2.imem_req), 16'h1);
        chk("rel_addr2", bus2.imem_addr, 16'hFFFE);

        // Sequential fetch with immediate acks; ack left high in VALID must be ignored
        for (int k = 0; k < 3; k++) begin
            chk("t1_req",   16'(bus.imem_req), 16'h1);
            chk("t1_addr",  bus.imem_addr, 16'(2 * k));
            chk("t1_valid0", 16'(instr_valid), 16'h0);
            bus.imem_ack = 1'b1;
            bus.imem_rdata = memv(16'(2 * k));
            step();
            chk("t1_valid1", 16'(instr_valid), 16'h1);
            chk("t1_noreq",  16'(bus.imem_req), 16'h0);
            chk("t1_ipc",    instr_pc, 16'(2 * k));
            chk("t1_ipcinc", instr_pc_inc, 16'(2 * k + 2));
            chk("t1_instr",  instr, memv(16'(2 * k)));
            if (k == 0) begin
                chk("t5_valid2",  16'(instr_valid2), 16'h1);
                chk("t5_ipc2",    instr_pc2, 16'hFFFE);
                chk("t5_ipcinc2", instr_pc_inc2, 16'h0000);
                chk("t5_instr2",  instr2, 16'h7E57);
                chk("t5_opc2",    16'(opcode2), 16'h7);
            end
            step();
            if (k == 0) begin
                chk("t5_req2",  16'(bus2.imem_req), 16'h1);
                chk("t5_addr2", bus2.imem_addr, 16'h0000);
            end
        end

        // Stall holds the instruction with no request issued
        bus.imem_rdata = 16'hB123;
        step();
        bus.imem_ack = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", 16'(instr_valid), 16'h1);
            chk("t2_instr", instr, 16'hB123);
            chk("t2_opc",   16'(opcode), 16'hB);
            chk("t2_noreq", 16'(bus.imem_req), 16'h0);
            chk("t2_ipc",   instr_pc, 16'h0006);
            step();
        end
        stall = 1'b0;
        step();
        chk("t2_req",  16'(bus.imem_req), 16'h1);
        chk("t2_addr", bus.imem_addr, 16'h0008);

        // Redirect overrides stall in VALID; odd target bit is dropped
        bus.imem_ack = 1'b1; bus.imem_rdata = memv(16'h0008);
        step();
        bus.imem_ack = 1'b0;
        stall = 1'b1; redir_v = 1'b1; redir_pc = 16'h0041;
        step();
        stall = 1'b0; redir_v = 1'b0;
        chk("t3_valid", 16'(instr_valid), 16'h0);
        chk("t3_req",   16'(bus.imem_req), 16'h1);
        chk("t3_addr",  bus.imem_addr, 16'h0040);
        chk("t3_stale", instr, memv(16'h0008));

        // Redirect while a request waits for a late ack
        bus.imem_ack = 1'b1; bus.imem_rdata = memv(16'h0040);
        step();
        bus.imem_ack = 1'b0; redir_v = 1'b1; redir_pc = 16'h0010;
        step();
        redir_v = 1'b0;
        chk("t4_addr0", bus.imem_addr, 16'h0010);
        step();
        redir_v = 1'b1; redir_pc = 16'h0070;
        chk("t4_addr1", bus.imem_addr, 16'h0010);
        step();
        redir_pc = 16'h0080;
        chk("t4_addr2", bus.imem_addr, 16'h0010);
        chk("t4_req2",  16'(bus.imem_req), 16'h1);
        step();
        redir_v = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = memv(16'h0010);
        chk("t4_addr3", bus.imem_addr, 16'h0010);
        step();
        bus.imem_ack = 1'b0;
        chk("t4_valid", 16'(instr_valid), 16'h0);
        chk("t4_req",   16'(bus.imem_req), 16'h1);
        chk("t4_naddr", bus.imem_addr, 16'h0080);

        // Ack and redirect in the same cycle discard the data
        bus.imem_ack = 1'b1; bus.imem_rdata = memv(16'h0080);
        redir_v = 1'b1; redir_pc = 16'h00A0;
        step();
        bus.imem_ack = 1'b0; redir_v = 1'b0;
        chk("t4b_valid", 16'(instr_valid), 16'h0);
        chk("t4b_addr",  bus.imem_addr, 16'h00A0);

        // Asynchronous reset mid-FETCH and mid-VALID
        #2 rst_n = 1'b0;
        #1;
        chk("t6f_req",   16'(bus.imem_req), 16'h0);
        chk("t6f_valid", 16'(instr_valid), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6f_rreq",  16'(bus.imem_req), 16'h1);
        chk("t6f_raddr", bus.imem_addr, 16'h0000);
        bus.imem_ack = 1'b1; bus.imem_rdata = memv(16'h0000);
        step();
        bus.imem_ack = 1'b0;
        chk("t6v_pre",   16'(instr_valid), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6v_req",   16'(bus.imem_req), 16'h0);
        chk("t6v_valid", 16'(instr_valid), 16'h0);
        chk("t6v_instr", instr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6v_rreq",  16'(bus.imem_req), 16'h1);
        chk("t6v_raddr", bus.imem_addr, 16'h0000);

        // Randomized traffic against the transaction-level model
        exp_valid = 1'b0; in_req = 1'b0; dirty = 1'b0;
        req_addr = 16'h0; arch_next = 16'h0; m_ipc = 16'h0;
        for (int n = 0; n < 3000; n++) begin
            chk("r_valid", 16'(instr_valid), 16'(exp_valid));
            chk("r_req",   16'(bus.imem_req), 16'(!exp_valid));
            if (exp_valid) begin
                exp_word = memv(m_ipc);
                chk("r_ipc",    instr_pc, m_ipc);
                chk("r_ipcinc", instr_pc_inc, m_ipc + 16'h2);
                chk("r_instr",  instr, exp_word);
                chk("r_opc",    16'(opcode), 16'(exp_word[15:12]));
            end else begin
                if (!in_req) begin
                    req_addr = arch_next;
                    in_req = 1'b1;
                end
                chk("r_addr", bus.imem_addr, req_addr);
            end

            stall    = ($urandom_range(0, 2) == 0);
            redir_v  = ($urandom_range(0, 9) == 0);
            redir_pc = 16'($urandom);
            bus.imem_ack   = ($urandom_range(0, 2) == 0);
            bus.imem_rdata = exp_valid ? 16'($urandom) : memv(req_addr);
            tgt = redir_pc & 16'hFFFE;

            if (exp_valid) begin
                if (redir_v) begin
                    arch_next = tgt;
                    exp_valid = 1'b0;
                end else if (!stall) begin
                    exp_valid = 1'b0;
                end
            end else if (bus.imem_ack) begin
                in_req = 1'b0;
                if (redir_v || dirty) begin
                    if (redir_v) arch_next = tgt;
                    dirty = 1'b0;
                end else begin
                    m_ipc = req_addr;
                    arch_next = req_addr + 16'h2;
                    exp_valid = 1'b1;
                end
            end else if (redir_v) begin
                arch_next = tgt;
                dirty = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
